// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Brief    : Register map, STATUS bit positions and transmit FSM encoding
//            shared by the buffered UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

    localparam logic [3:0] REG_TXDATA = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_LEVEL  = 4'd2;
    localparam logic [3:0] REG_DIVLO  = 4'd3;
    localparam logic [3:0] REG_DIVHI  = 4'd4;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [15:0] MIN_DIV = 16'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Parameterised single-clock FIFO with combinational head output;
//            a push into a full FIFO is accepted when a pop happens together.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == c_DEPTH);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Memory-mapped 8N1 UART transmitter with TX FIFO. Define
//            UART_TX_BAUD_PROG_EN for a run-time programmable baud divisor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [3:0]  rd_addr,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [7:0]  rd_data,
    input  logic        wr_en,
    output logic        uart_tx
);

    localparam int          LW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'((CLK_FREQ + BAUD/2) / BAUD);

    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_dout;
    logic            w_full;
    logic            w_empty;
    logic [LW-1:0]   w_level;
    logic [15:0]     w_div;

    tx_state_t       r_state, w_state_nxt;
    logic [15:0]     r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_tx, w_tx_nxt;
    logic [15:0]     r_div_act, w_div_act_nxt;
    logic            r_ovf;
    logic [7:0]      r_rd_data, w_rd_nxt;

    assign w_push = wr_en && (wr_addr == REG_TXDATA);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTb  (RSTb),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wr_data[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

`ifdef UART_TX_BAUD_PROG_EN
    logic [15:0] r_div;
    wire         w_unused_wdata = ^wr_data[31:16];

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_div <= DIV_RST;
        end else if (wr_en && (wr_addr == REG_DIVLO)) begin
            r_div <= clamp_div(wr_data[15:0]);
        end
    end
    assign w_div = r_div;
`else
    wire         w_unused_wdata = ^wr_data[31:8];
    assign w_div = DIV_RST;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_div_act <= DIV_RST;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_div_act <= w_div_act_nxt;
        end
    end

    // The divisor is sampled once per frame so reprogramming never stretches a frame in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        w_div_act_nxt = r_div_act;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_dout;
                    w_div_act_nxt = w_div;
                    w_cnt_nxt     = w_div - 16'd1;
                    w_tx_nxt      = 1'b0;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == 16'd0) begin
                    w_cnt_nxt   = r_div_act - 16'd1;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == 16'd0) begin
                    w_cnt_nxt = r_div_act - 16'd1;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_cnt == 16'd0) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A push against a full FIFO is only lost when no pop frees a slot that cycle.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (wr_en && (wr_addr == REG_STATUS) && wr_data[STAT_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_rd_nxt = 8'h00;
        case (rd_addr)
            REG_STATUS: begin
                w_rd_nxt[STAT_FULL]  = w_full;
                w_rd_nxt[STAT_EMPTY] = w_empty;
                w_rd_nxt[STAT_BUSY]  = (r_state != ST_IDLE);
                w_rd_nxt[STAT_OVF]   = r_ovf;
            end
            REG_LEVEL: w_rd_nxt = 8'(w_level);
`ifdef UART_TX_BAUD_PROG_EN
            REG_DIVLO: w_rd_nxt = r_div[7:0];
            REG_DIVHI: w_rd_nxt = r_div[15:8];
`endif
            default:   w_rd_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= w_rd_nxt;
        end
    end

    assign rd_data = r_rd_data;
    assign uart_tx = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo at default params.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int DIV = 434;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_en = 1'b0;
    logic [7:0]  rd_data;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;

    uart_tx_fifo u_dut (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .uart_tx (uart_tx)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        wr_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] v);
        rd_addr = a;
        @(posedge CLK);
        @(negedge CLK);
        v = rd_data;
    endtask

    // Entered during the IDLE pop cycle; returns in the idle cycle after STOP.
    task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
        int   errs;
        int   idx;
        logic exp;
        errs = 0;
        for (int c = 1; c <= 10 * div; c++) begin
            @(negedge CLK);
            idx = (c - 1) / div;
            exp = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
            if (uart_tx !== exp) errs++;
        end
        check_value({tag, "_bit_errs"}, errs, 0);
        @(negedge CLK);
        check_value({tag, "_idle_gap"}, uart_tx, 1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] exp_rd;
        int         lows;

        RSTb = 1'b0;
        repeat (3) @(negedge CLK);
        check_value("rst_tx", uart_tx, 1);
        check_value("rst_rd_data", rd_data, 0);
        RSTb = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus_read(4'(i), v);
            exp_rd = (i == 1) ? 8'h02 : 8'h00;
`ifdef UART_TX_BAUD_PROG_EN
            if (i == 3) exp_rd = 8'hB2;
            if (i == 4) exp_rd = 8'h01;
`endif
            check_value($sformatf("reset_idx%0d", i), v, exp_rd);
        end
        check_value("reset_line_idle", uart_tx, 1);

        bus_write(REG_TXDATA, 32'h55);
        check_value("pop_cycle_high", uart_tx, 1);
        expect_frame(8'h55, DIV, "f55");
        bus_read(REG_STATUS, v);
        check_value("status_after_55", v, 8'h02);

        bus_write(REG_TXDATA, 32'h41);
        fork
            begin
                expect_frame(8'h41, DIV, "f41");
                expect_frame(8'h42, DIV, "f42");
                expect_frame(8'h43, DIV, "f43");
            end
            begin
                bus_write(REG_TXDATA, 32'h42);
                bus_write(REG_TXDATA, 32'h43);
            end
        join
        bus_read(REG_STATUS, v);
        check_value("status_after_abc", v, 8'h02);

`ifdef UART_TX_BAUD_PROG_EN
        bus_write(REG_TXDATA, 32'h3C);
        fork
            begin
                expect_frame(8'h3C, DIV, "fold_div");
                expect_frame(8'h5A, 16, "fnew_div");
            end
            begin
                bus_write(REG_TXDATA, 32'h5A);
                repeat (100) @(negedge CLK);
                bus_write(REG_DIVLO, 32'd5);
            end
        join
        bus_read(REG_DIVLO, v);
        check_value("divlo_clamped", v, 8'h10);
        bus_read(REG_DIVHI, v);
        check_value("divhi_clamped", v, 8'h00);
`else
        bus_write(REG_DIVLO, 32'd5);
        bus_read(REG_DIVLO, v);
        check_value("divlo_absent", v, 8'h00);
`endif

        for (int i = 0; i < 17; i++) begin
            bus_write(REG_TXDATA, 32'h80 + 32'(i));
        end
        bus_read(REG_STATUS, v);
        check_value("status_full_no_ovf", v, 8'h05);
        bus_read(REG_LEVEL, v);
        check_value("level_full", v, 8'h10);
        bus_write(REG_TXDATA, 32'hEE);
        bus_read(REG_STATUS, v);
        check_value("status_ovf", v, 8'h0D);
        bus_read(REG_LEVEL, v);
        check_value("level_after_drop", v, 8'h10);
        bus_write(REG_STATUS, 32'h07);
        bus_read(REG_STATUS, v);
        check_value("ovf_kept", v, 8'h0D);
        bus_write(REG_STATUS, 32'h08);
        bus_read(REG_STATUS, v);
        check_value("ovf_cleared", v, 8'h05);
        bus_read(REG_TXDATA, v);
        check_value("txdata_reads_zero", v, 8'h00);

        RSTb = 1'b0;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        bus_read(REG_LEVEL, v);
        check_value("level_after_reset", v, 8'h00);

        // 0xA5 data bit 3 is 0, so the line is low just before the reset pulse.
        bus_write(REG_TXDATA, 32'hA5);
        bus_write(REG_TXDATA, 32'h00);
        repeat (1900) @(negedge CLK);
        check_value("pre_reset_bit3", uart_tx, 0);
        RSTb = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_value("reset_mid_frame_tx", uart_tx, 1);
        RSTb = 1'b1;
        bus_read(REG_LEVEL, v);
        check_value("reset_mid_frame_level", v, 8'h00);
        bus_read(REG_STATUS, v);
        check_value("reset_mid_frame_status", v, 8'h02);
        lows = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (uart_tx !== 1'b1) lows++;
        end
        check_value("line_quiet_after_reset", lows, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
